// File: rtl/hs_arbiter.sv
// Round-robin arbiter: several 4-phase requesters share one 4-phase downstream channel; grant 1 cycle after IDLE sees a request.
// Downstream ack_out paces each transaction; define HS_ARBITER_TIMEOUT_EN for a sticky watchdog on err.
module hs_arbiter #(
  parameter int size    = 2,
  parameter int timeout = 15
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [size-1:0]                               req_in,
  output logic [size-1:0]                               ack_in,
  output logic                                          req_out,
  input  logic                                          ack_out,
  output logic [((size > 1) ? $clog2(size) : 1)-1:0]    gnt_idx,
  output logic                                          busy,
  output logic                                          err
);

  localparam int IW = (size > 1) ? $clog2(size) : 1;

  typedef enum logic [1:0] {IDLE, REQ, ACK, REL} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;

  // Walk from the farthest candidate back to ptr+1 so the nearest set bit wins.
  always_comb begin
    win  = ptr;
    cand = '0;
    for (int i = size; i >= 1; i--) begin
      cand = IW'((int'(ptr) + i) % size);
      if (req_in[cand]) win = cand;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= IW'(size - 1);
      gnt_idx <= '0;
      req_out <= 1'b0;
      ack_in  <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_in) begin
          gnt_idx <= win;
          req_out <= 1'b1;
          busy    <= 1'b1;
          state   <= REQ;
        end
        REQ: if (ack_out) begin
          ack_in[gnt_idx] <= 1'b1;
          state           <= ACK;
        end
        ACK: if (!req_in[gnt_idx]) begin
          req_out <= 1'b0;
          state   <= REL;
        end
        REL: if (!ack_out) begin
          ack_in <= '0;
          ptr    <= gnt_idx;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HS_ARBITER_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       leave;

  always_comb begin
    leave = 1'b0;
    case (state)
      IDLE:    leave = |req_in;
      REQ:     leave = ack_out;
      ACK:     leave = !req_in[gnt_idx];
      REL:     leave = !ack_out;
      default: leave = 1'b0;
    endcase
  end

  // Only the phases waiting on the downstream side are watched; err never forces the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else if (leave) begin
      wd_cnt <= '0;
    end else if (state == REQ || state == REL) begin
      if (wd_cnt != 8'hff) wd_cnt <= wd_cnt + 8'd1;
      if (wd_cnt == 8'(timeout - 1)) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hs_arbiter.sv
// Randomized bench for hs_arbiter: acts as requesters and downstream, predicts grants with a round-robin model.
module tb_hs_arbiter;

  localparam int SZ = 2;
  localparam int TO = 15;
`ifdef HS_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [SZ-1:0] req_in;
  logic [SZ-1:0] ack_in;
  logic          req_out;
  logic          ack_out;
  logic [0:0]    gnt_idx;
  logic          busy;
  logic          err;

  int total;
  int bad;
  int ptr_m;
  int w_obs;
  logic [SZ-1:0] pend;

  hs_arbiter #(.size(SZ), .timeout(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_in  (req_in),
    .ack_in  (ack_in),
    .req_out (req_out),
    .ack_out (ack_out),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester index that wins: first pending channel after the last winner, wrapping around.
  function automatic int rr_pick(input int p, input logic [SZ-1:0] r);
    logic [SZ-1:0] sh;
    for (int k = 1; k <= SZ; k++) begin
      sh = r >> ((p + k) % SZ);
      if (sh[0]) return (p + k) % SZ;
    end
    return -1;
  endfunction

  function automatic logic [SZ-1:0] glitch_bits(input bit en, input int w);
    logic [SZ-1:0] one;
    one = 1;
    if (!en) return '0;
    return SZ'($urandom) & ~pend & ~(one << w);
  endfunction

  // Called just after a negedge; asserts reset off-edge and checks outputs clear without a clock.
  task automatic do_reset(input bit clear_reqs);
    #2 rst = 1'b0;
    ack_out = 1'b0;
    if (clear_reqs) begin
      pend   = '0;
      req_in = '0;
    end
    #1;
    chk("rst_req_out", int'(req_out), 0);
    chk("rst_ack_in", int'(ack_in), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gnt", int'(gnt_idx), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    rst   = 1'b1;
    ptr_m = SZ - 1;
  endtask

  // DUT must be idle at the current negedge; runs one full 4-phase transaction.
  task automatic run_txn(input logic [SZ-1:0] add, input int rw, input int aw,
                         input int lw, input bit gl, output int w_seen);
    int w;
    logic [SZ-1:0] one;
    logic [SZ-1:0] ackx;
    one  = 1;
    pend = pend | add;
    if (pend == '0) pend = one << $urandom_range(0, SZ - 1);
    w    = rr_pick(ptr_m, pend);
    ackx = one << w;
    req_in = pend;
    @(negedge clk);
    w_seen = int'(gnt_idx);
    chk("grant_req_out", int'(req_out), 1);
    chk("grant_idx", int'(gnt_idx), w);
    chk("grant_busy", int'(busy), 1);
    chk("grant_ack_in", int'(ack_in), 0);
    for (int i = 0; i < rw; i++) begin
      req_in = pend | glitch_bits(gl, w);
      @(negedge clk);
      chk("req_wait_ack_in", int'(ack_in), 0);
      chk("req_wait_req_out", int'(req_out), 1);
    end
    ack_out = 1'b1;
    req_in  = pend | glitch_bits(gl, w);
    @(negedge clk);
    chk("ack_ack_in", int'(ack_in), int'(ackx));
    chk("ack_req_out", int'(req_out), 1);
    for (int i = 0; i < aw; i++) begin
      req_in = pend | glitch_bits(gl, w);
      @(negedge clk);
      chk("ack_hold_ack_in", int'(ack_in), int'(ackx));
      chk("ack_hold_req_out", int'(req_out), 1);
    end
    pend   = pend & ~ackx;
    req_in = pend | glitch_bits(gl, w);
    @(negedge clk);
    chk("rel_req_out", int'(req_out), 0);
    chk("rel_ack_in", int'(ack_in), int'(ackx));
    chk("rel_busy", int'(busy), 1);
    for (int i = 0; i < lw; i++) begin
      req_in = pend | glitch_bits(gl, w);
      @(negedge clk);
      chk("rel_hold_ack_in", int'(ack_in), int'(ackx));
    end
    ack_out = 1'b0;
    @(negedge clk);
    chk("idle_ack_in", int'(ack_in), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_req_out", int'(req_out), 0);
    chk("idle_gnt_hold", int'(gnt_idx), w);
    chk("idle_err", int'(err), 0);
    ptr_m  = w;
    req_in = pend;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    req_in  = '0;
    ack_out = 1'b0;
    pend    = '0;
    ptr_m   = SZ - 1;
    #3;
    chk("por_req_out", int'(req_out), 0);
    chk("por_ack_in", int'(ack_in), 0);
    chk("por_busy", int'(busy), 0);
    chk("por_gnt", int'(gnt_idx), 0);
    chk("por_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_out", int'(req_out), 0);
    chk("post_rst_busy", int'(busy), 0);

    // Single transaction on channel 1, downstream answers after 2 cycles.
    run_txn(2'b10, 2, 0, 0, 1'b0, w_obs);
    chk("single_gnt", w_obs, 1);

    // Both requesters kept asking: order after reset must be 0, 1, 0.
    do_reset(1'b1);
    run_txn(2'b11, 1, 0, 0, 1'b0, w_obs);
    chk("rr_first", w_obs, 0);
    run_txn(2'b01, 1, 0, 0, 1'b0, w_obs);
    chk("rr_second", w_obs, 1);
    run_txn(2'b10, 1, 0, 0, 1'b0, w_obs);
    chk("rr_third", w_obs, 0);

    // Abort in ACK, then re-arbitrate on the still-held requests.
    pend   = 2'b10;
    req_in = pend;
    @(negedge clk);
    ack_out = 1'b1;
    @(negedge clk);
    chk("abort_pre_ack_in", int'(ack_in), 2);
    do_reset(1'b0);
    run_txn('0, 1, 1, 1, 1'b0, w_obs);
    chk("abort_regrant", w_obs, 1);

    for (int t = 0; t < 200; t++) begin
      run_txn(SZ'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'b1, w_obs);
    end

    // Watchdog: stall in REQ with ack_out low.
    do_reset(1'b1);
    pend   = 2'b01;
    req_in = pend;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      chk("wd_err", int'(err), (TO_EN && k >= TO) ? 1 : 0);
    end
    ack_out = 1'b1;
    @(negedge clk);
    pend   = '0;
    req_in = '0;
    @(negedge clk);
    ack_out = 1'b0;
    @(negedge clk);
    chk("wd_idle_busy", int'(busy), 0);
    chk("wd_sticky", int'(err), TO_EN ? 1 : 0);
    do_reset(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
